// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the synchronous instruction ROM and pairs each returned word
// with its PC. Each presented instruction also carries a hold buffer so it survives a decode stall.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] req_pc_q;
    logic        hold_q;
    logic [31:0] hold_inst_q;
    logic [31:0] hold_pc_q;

    logic        v;
    logic        issue;
    logic [31:0] fetch_addr;
    logic        unused_flush_bits;

    assign unused_flush_bits = ^flush_pc_i[1:0];

    // Handshake: an instruction transfers on any cycle with out_valid & out_ready. Once raised,
    // out_valid stays up with stable pc/inst until that transfer, unless a flush or reset intervenes.
    assign v          = hold_q | req_q;
    assign issue      = rst & (flush_i | ~v | out_ready);
    assign fetch_addr = flush_i ? {flush_pc_i[31:2], 2'b00} : pc_q;

    assign rom_en    = issue;
    assign rom_addr  = fetch_addr;
    assign out_valid = rst & v & ~flush_i;

    always_comb begin
        out_pc   = req_pc_q;
        out_inst = '0;
        if (hold_q) begin
            out_pc   = hold_pc_q;
            out_inst = hold_inst_q;
        end else if (req_q) begin
            out_inst = rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= {RESET_PC[31:2], 2'b00};
            req_q       <= 1'b0;
            req_pc_q    <= '0;
            hold_q      <= 1'b0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else if (issue) begin
            req_q    <= 1'b1;
            req_pc_q <= fetch_addr;
            pc_q     <= fetch_addr + 32'd4;
            hold_q   <= 1'b0;
        end else if (v) begin
            // Stalled: the ROM word is only on rom_data for one cycle, so park it here.
            req_q <= 1'b0;
            if (req_q) begin
                hold_q      <= 1'b1;
                hold_inst_q <= rom_data;
                hold_pc_q   <= req_pc_q;
            end
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the synchronous instruction ROM.
- Generates the PC and drives the ROM enable/address pair.
- Pairs the ROM's one-cycle-late data with the PC that requested it.
- Presents {pc, inst} to the decode stage over a valid/ready handshake, with branch/jump redirect (flush) and backpressure-safe holding of the returned word.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-low (0 = reset).
- flush_i  input  1  redirect request from execute/branch unit.
- flush_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 0).
- rom_en  output  1  ROM read enable (combinational).
- rom_addr  output  32  ROM byte address (combinational), always word aligned.
- rom_data  input  32  ROM read data, valid the cycle after rom_en=1.
- out_valid  output  1  {out_pc, out_inst} is a valid instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_pc  output  32  PC of the presented instruction.
- out_inst  output  32  presented instruction word.

Behaviour:
- State registers:
  - pc_q: next fetch PC.
  - req_q: a request was issued last cycle; data is on rom_data now.
  - req_pc_q: PC of that request.
  - hold_q, hold_inst_q, hold_pc_q: captured word.
- Reset (rst=0 at posedge): pc_q=RESET_PC, req_q=0, req_pc_q=0, hold_q=0, hold_inst_q=0, hold_pc_q=0.
- While rst=0: rom_en=0, out_valid=0.
- Outputs after reset:
  - rom_addr = RESET_PC until the first issue.
  - out_pc = 0, out_inst = 0.
- Internal valid: v = hold_q | req_q.
- Output mux:
  - If hold_q: out_inst = hold_inst_q, out_pc = hold_pc_q.
  - Else: out_inst = rom_data, out_pc = req_pc_q.
- out_valid = rst & v & ~flush_i. Flush masks the output in the flush cycle; decode must not see a wrong-path instruction.
- Issue condition: issue = rst & (flush_i | ~v | out_ready). rom_en = issue.
- rom_addr = flush_i ? {flush_pc_i[31:2],2'b00} : pc_q.
- On issue (posedge):
  - req_q <= 1, req_pc_q <= rom_addr.
  - pc_q <= rom_addr + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - hold_q <= 0.
- No issue, v=1 (stall, out_ready=0, no flush):
  - req_q <= 0.
  - If req_q=1: capture hold_q <= 1, hold_inst_q <= rom_data, hold_pc_q <= req_pc_q.
  - If already holding: hold unchanged. The held word stays stable regardless of later rom_data changes.
  - pc_q unchanged.
- No issue, v=0 can only occur while rst=0.
- Latency and throughput:
  - Instruction at PC X, issued in cycle t, is out_valid in cycle t+1.
  - Streaming with out_ready=1 gives 1 instruction/cycle, PCs consecutive +4.
- Stall: out_pc/out_inst held constant every stalled cycle; exactly one request outstanding; no PC skipped or duplicated on release.
- Flush:
  - Wins over stall and over any pending/held word: hold_q <= 0, in-flight data discarded.
  - Target is issued in the same cycle as flush_i, so the target is out_valid the next cycle (one-bubble redirect).
- Back-to-back flushes: each flush cycle re-issues its own target; only the last target's data is presented.
- Reset mid-operation: held/in-flight words are dropped; fetch restarts at RESET_PC on the first cycle with rst=1 (rom_en=1, rom_addr=RESET_PC).
- Handshake is complete when out_valid & out_ready in the same cycle. out_valid never drops without a handshake, except for a flush or reset.

Test Plan:
- Reset then stream: ROM model word[i]=32'hA000_0000+i; hold rst=0 3 cycles then 1 with out_ready=1.
  - rom_en=0 during reset.
  - First rom_en cycle has addr 0.
  - The next cycle has out_valid=1, pc=0, inst=A000_0000; then pc 4,8,12 each cycle.
- Stall: drop out_ready for 4 cycles while pc=0x8 is presented.
  - out_pc=0x8 and inst=A000_0002 stay constant, rom_en=0 during the stall.
  - After release the sequence continues 0xC, 0x10 with no gap or duplicate.
- Held-word integrity: during the stall, force rom_data to garbage (DEAD_BEEF).
  - out_inst remains A000_0002 throughout.
- Flush while stalled: pc=0x10 presented, out_ready=0, flush_i=1, flush_pc_i=0x43.
  - Flush cycle: out_valid=0, rom_en=1, rom_addr=0x40.
  - Next cycle: pc=0x40, inst=A000_0010.
  - Then 0x44.
- Wrap-around: RESET_PC=32'hFFFF_FFF8.
  - Presented PCs: FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-stall: assert rst=0 for 1 cycle while holding a word.
  - Held word dropped, out_valid=0.
  - Fetch restarts at RESET_PC; first valid output is pc=RESET_PC.
